// File: rtl/game_pkg.sv
// Shared screen geometry, colours and FSM encoding for the pixel-plot datapath.
package game_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = $clog2(SCREEN_W);
  localparam int Y_W = $clog2(SCREEN_H);
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_UPDATE,
    ST_DRAW
  } box_state_t;
endpackage

// File: rtl/box_controller_if.sv
// Frame-tick/jump inputs and pixel-write outputs of the box controller.
interface box_controller_if;
  import game_pkg::*;

  logic           frame_tick;
  logic           jump;
  logic           plot;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           busy;
  logic [Y_W-1:0] box_y;

  modport master (
    output frame_tick, jump,
    input  plot, x, y, colour, busy, box_y
  );

  modport slave (
    input  frame_tick, jump,
    output plot, x, y, colour, busy, box_y
  );
endinterface

// File: rtl/box_pixel_counter.sv
// Row-major dx/dy sweep over a W x H box; wraps to (0,0) after the last pixel.
module box_pixel_counter #(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);
  assign last = (dx == 3'(W - 1)) && (dy == 3'(H - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx == 3'(W - 1)) begin
        dx <= '0;
        dy <= last ? 3'd0 : dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end
endmodule

// File: rtl/box_controller.sv
// Per frame: erase box, apply jump/gravity, redraw; one registered pixel per clock.
// Tick sampled at cycle 0 gives erase pixels on 1..N, update on N+1, draw on N+2..2N+1.
module box_controller
  import game_pkg::*;
#(
  parameter int BOX_X    = 2,
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int Y_MAX    = SCREEN_H - BOX_H,
  parameter int GRAVITY  = 1,
  parameter int JUMP_VEL = 6,
  parameter int V_MAX    = 7
) (
  input logic             clk,
  input logic             reset,
  box_controller_if.slave bus
);
  localparam logic [Y_W-1:0]    Y_TOP = Y_W'(Y_MAX);
  localparam logic signed [8:0] V_TOP = 9'(V_MAX);

  box_state_t        state;
  logic [Y_W-1:0]    box_y_q, y_new;
  logic signed [4:0] vel, vel_new;
  logic              done;
  logic              plot_q, busy_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [2:0]        colour_q;
  logic [2:0]        dx, dy;
  logic              last;
  logic              cnt_clear, cnt_en;
  logic signed [8:0] vel_inc, vel_next, y_sum;

  // The counter always points at the pixel being registered this cycle, so
  // the output registers can present pixel k on the cycle after it is chosen.
  assign cnt_clear = (state == ST_IDLE) && !bus.frame_tick;
  assign cnt_en    = ((state == ST_IDLE) && bus.frame_tick) || (state == ST_UPDATE) ||
                     (((state == ST_ERASE) || (state == ST_DRAW)) && !done);

  box_pixel_counter #(.W(BOX_W), .H(BOX_H)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  always_comb begin
    vel_inc = 9'(vel) + 9'(GRAVITY);
    if (bus.jump && (box_y_q == Y_TOP)) vel_next = -9'(JUMP_VEL);
    else if (vel_inc > V_TOP)          vel_next = V_TOP;
    else                               vel_next = vel_inc;
    y_sum   = $signed({2'b00, box_y_q}) + vel_next;
    y_new   = box_y_q;
    vel_new = vel;
    if (y_sum < 0) begin
      y_new   = '0;
      vel_new = '0;
    end else if (y_sum > 9'(Y_MAX)) begin
      y_new   = Y_TOP;
      vel_new = '0;
    end else begin
      y_new   = y_sum[Y_W-1:0];
      vel_new = vel_next[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      box_y_q  <= Y_TOP;
      vel      <= '0;
      done     <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= COL_BLACK;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            state    <= ST_ERASE;
            busy_q   <= 1'b1;
            plot_q   <= 1'b1;
            x_q      <= X_W'(BOX_X) + X_W'(dx);
            y_q      <= box_y_q + Y_W'(dy);
            colour_q <= COL_BLACK;
            done     <= last;
          end
        end
        ST_UPDATE: begin
          box_y_q  <= y_new;
          vel      <= vel_new;
          state    <= ST_DRAW;
          plot_q   <= 1'b1;
          x_q      <= X_W'(BOX_X) + X_W'(dx);
          y_q      <= y_new + Y_W'(dy);
          colour_q <= COL_WHITE;
          done     <= last;
        end
        default: begin
          // Shared by ERASE and DRAW: a spare cycle after the last pixel
          // drops plot before moving on.
          if (done) begin
            plot_q <= 1'b0;
            done   <= 1'b0;
            if (state == ST_DRAW) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= ST_UPDATE;
            end
          end else begin
            plot_q <= 1'b1;
            x_q    <= X_W'(BOX_X) + X_W'(dx);
            y_q    <= box_y_q + Y_W'(dy);
            done   <= last;
          end
        end
      endcase
    end
  end

  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.busy   = busy_q;
  assign bus.box_y  = box_y_q;
endmodule

// File: tb/tb_box_controller.sv
// Scoreboard bench: two controllers (jump velocity 6 and 15) share one random stimulus.
module tb_box_controller;
  import game_pkg::*;

  localparam int N = 16;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic jump = 1'b0;

  always #5 clk = ~clk;

  box_controller_if bus_a ();
  box_controller_if bus_b ();

  assign bus_a.frame_tick = frame_tick;
  assign bus_a.jump       = jump;
  assign bus_b.frame_tick = frame_tick;
  assign bus_b.jump       = jump;

  box_controller #(.JUMP_VEL(6))  dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  box_controller #(.JUMP_VEL(15)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  px_t q0[$];
  px_t q1[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  e_acc = 0;
  int  next_ok = 0;
  bit  in_frame = 1'b0;
  bit  exp_busy = 1'b0;
  int  m_y[2] = '{116, 116};
  int  m_vel[2] = '{0, 0};
  int  jv[2] = '{6, 15};

  function automatic void push_box(int d, int top, int col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        px_t p;
        p.x = 2 + c;
        p.y = top + r;
        p.c = col;
        if (d == 0) q0.push_back(p);
        else        q1.push_back(p);
      end
  endfunction

  // Physics per frame, straight from the jump/gravity/clamp rules.
  function automatic void physics(int d, bit jmp);
    int v, s;
    if (jmp && m_y[d] == 116) v = -jv[d];
    else v = (m_vel[d] + 1 > 7) ? 7 : m_vel[d] + 1;
    s = m_y[d] + v;
    if (s < 0) begin
      m_y[d] = 0;
      m_vel[d] = 0;
    end else if (s > 116) begin
      m_y[d] = 116;
      m_vel[d] = 0;
    end else begin
      m_y[d] = s;
      m_vel[d] = v;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        m_y[d] = 116;
        m_vel[d] = 0;
      end
      in_frame = 1'b0;
      next_ok = 0;
    end else begin
      if (in_frame && cyc == e_acc + N + 1)
        for (int d = 0; d < 2; d++) begin
          physics(d, jump);
          push_box(d, m_y[d], 7);
        end
      if (frame_tick && cyc >= next_ok) begin
        e_acc = cyc;
        next_ok = cyc + 2 * N + 2;
        in_frame = 1'b1;
        for (int d = 0; d < 2; d++) push_box(d, m_y[d], 0);
      end
    end
    exp_busy = in_frame && (cyc <= e_acc + 2 * N);
  end

  function automatic void check_px(int d, logic p, logic [7:0] xv, logic [6:0] yv, logic [2:0] cv);
    px_t e;
    if (!p) return;
    total++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL plot%0d unexpected pixel at cycle %0d: got x=%0d y=%0d c=%0d, want no plot", d, cyc, xv, yv, cv);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (xv !== 8'(e.x) || yv !== 7'(e.y) || cv !== 3'(e.c)) begin
      bad++;
      $display("FAIL pixel%0d cycle %0d: got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d",
               d, cyc, xv, yv, cv, e.x, e.y, e.c);
    end
  endfunction

  always @(negedge clk) begin
    check_px(0, bus_a.plot, bus_a.x, bus_a.y, bus_a.colour);
    check_px(1, bus_b.plot, bus_b.x, bus_b.y, bus_b.colour);
    total += 4;
    if (bus_a.busy !== exp_busy) begin
      bad++;
      $display("FAIL busy0 cycle %0d: got %0b want %0b", cyc, bus_a.busy, exp_busy);
    end
    if (bus_b.busy !== exp_busy) begin
      bad++;
      $display("FAIL busy1 cycle %0d: got %0b want %0b", cyc, bus_b.busy, exp_busy);
    end
    if (bus_a.box_y !== 7'(m_y[0])) begin
      bad++;
      $display("FAIL box_y0 cycle %0d: got %0d want %0d", cyc, bus_a.box_y, m_y[0]);
    end
    if (bus_b.box_y !== 7'(m_y[1])) begin
      bad++;
      $display("FAIL box_y1 cycle %0d: got %0d want %0d", cyc, bus_b.box_y, m_y[1]);
    end
  end

  task automatic pulse_at(input int edge_no);
    while (cyc < edge_no - 1) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc + 1 < next_ok) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL wait_idle timeout at cycle %0d: got still busy, want idle", cyc);
        break;
      end
    end
  endtask

  task automatic tick();
    wait_idle();
    pulse_at(cyc + 1);
  endtask

  initial begin
    int ea;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus_a.plot, bus_a.x, bus_a.y, bus_a.colour, bus_b.plot, bus_b.x, bus_b.y, bus_b.colour} !== '0) begin
      bad++;
      $display("FAIL reset_out: got a=%0b/%0d/%0d/%0d b=%0b/%0d/%0d/%0d, want all 0",
               bus_a.plot, bus_a.x, bus_a.y, bus_a.colour, bus_b.plot, bus_b.x, bus_b.y, bus_b.colour);
    end

    // Idle frame, then jump off the ground and fall back to land.
    jump = 1'b0;
    tick();
    jump = 1'b1;
    tick();
    wait_idle();
    jump = 1'b0;
    repeat (13) tick();

    // Repeated jumps: the 15-unit controller reaches the ceiling.
    jump = 1'b1;
    repeat (16) tick();
    jump = 1'b0;
    repeat (12) tick();

    // Ticks during a busy frame are dropped; the one at cycle 34 is taken.
    wait_idle();
    ea = cyc + 1;
    pulse_at(ea);
    pulse_at(ea + 5);
    pulse_at(ea + 20);
    pulse_at(ea + 34);

    // Reset in the middle of the draw sweep, then a clean frame.
    wait_idle();
    jump = 1'b1;
    ea = cyc + 1;
    pulse_at(ea);
    while (cyc < ea + 24) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    jump = 1'b0;
    tick();

    // Random ticks and jump levels, including ticks while busy.
    repeat (1200) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 9) == 0);
      jump = 1'($urandom_range(0, 1));
    end
    frame_tick = 1'b0;

    wait_idle();
    repeat (3) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pixels outstanding, want 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
